// File: rtl/dac_write_sched.sv
// Round-robin scheduler sharing one parallel DAC between NCH code producers,
// sequencing the latch strobe with programmable setup, pulse and hold times.
module dac_write_sched #(
   parameter int unsigned NCH     = 2,
   parameter int unsigned DW      = 12,
   parameter int unsigned CW      = 1,
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 2,
   parameter int unsigned T_HOLD  = 1
) (
   input  logic              clk,
   input  logic              nCR,
   input  logic              en,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH*DW-1:0] req_data,
   output logic [NCH-1:0]    req_ready,
   output logic [DW-1:0]     dac,
   output logic [CW-1:0]     dac_sel,
   output logic              dac_CP,
   output logic              busy,
   output logic              done
);

   localparam int unsigned T_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
   localparam int unsigned T_MAX = (T_SP > T_HOLD) ? T_SP : T_HOLD;
   localparam int unsigned CNTW = $clog2(T_MAX) + 1;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic [CW-1:0]     ptr;
   logic [CW-1:0]     gnt;
   logic              found;
   logic              xfer;
   int unsigned       idx;

   // Search upward from the pointer, wrapping, for the first valid requester.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = CW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      xfer      = (state == IDLE) && en && nCR && found;
      if (xfer) req_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!nCR) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         dac     <= '0;
         dac_sel <= '0;
         dac_CP  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  dac     <= req_data[32'(gnt)*DW +: DW];
                  dac_sel <= gnt;
                  ptr     <= (32'(gnt) == NCH - 1) ? '0 : gnt + CW'(1);
                  cnt     <= CNTW'(T_SETUP - 1);
                  busy    <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  cnt    <= CNTW'(T_PULSE - 1);
                  dac_CP <= 1'b1;
                  state  <= STROBE;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  cnt    <= CNTW'(T_HOLD - 1);
                  dac_CP <= 1'b0;
                  done   <= (T_HOLD == 1);
                  state  <= HOLD;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end
            HOLD: begin
               // done is staged so it is high exactly in the last hold cycle
               if (cnt == '0) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt  <= cnt - CNTW'(1);
                  done <= (cnt == CNTW'(1));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
